aopd_pd_seq: RTL and testbench

//  Power-domain sequencer in the always-on power domain (AOPD). Drives the isolation-select
//  (sel_iso) inputs of the iso_cell instances, the switched-domain reset and the power-switch

---
 rtl/aopd_pd_seq.sv | 156 +++++++++++++++
 tb/tb_aopd_pd_seq.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/aopd_pd_seq.sv
// Always-on power-domain sequencer for isolation, switched-domain reset and power-switch enable.
// Outputs are registered, decoded from the next state so they change in the same cycle as the state.
module aopd_pd_seq #(
  parameter int ISO_DLY = 4,
  parameter int RST_DLY = 4,
  parameter int PWR_TMO = 255,
  parameter int CNT_W   = 8
) (
  input  logic       i_aopd_clk,
  input  logic       i_aopd_rst,
  input  logic       i_pd_off_req,
  input  logic       i_pd_on_req,
  input  logic       i_pd_pwr_ok,
  output logic       o_pd_ack,
  output logic       o_pd_err,
  output logic       o_sel_iso,
  output logic       o_pd_rst,
  output logic       o_pd_pwr_en,
  output logic [2:0] o_pd_state
);

  typedef enum logic [2:0] {
    S_ON      = 3'd0,
    S_ISO     = 3'd1,
    S_RST     = 3'd2,
    S_PWR_DN  = 3'd3,
    S_OFF     = 3'd4,
    S_PWR_UP  = 3'd5,
    S_RST_REL = 3'd6,
    S_ISO_REL = 3'd7
  } state_t;

  localparam logic [CNT_W-1:0] ISO_LD = CNT_W'(ISO_DLY - 1);
  localparam logic [CNT_W-1:0] RST_LD = CNT_W'(RST_DLY - 1);
  localparam logic [CNT_W-1:0] TMO_LD = CNT_W'(PWR_TMO - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_cnt_done;
  logic             w_err_set;
  logic             w_err_clr;
  logic             w_sel_iso_nxt;
  logic             w_pd_rst_nxt;
  logic             w_pwr_en_nxt;
  logic             w_ack_nxt;
  logic             w_err_nxt;

  assign w_cnt_done = (r_cnt == {CNT_W{1'b0}});

  // State, counter and registered outputs
  always_ff @(posedge i_aopd_clk) begin
    if (i_aopd_rst) begin
      r_state     <= S_ON;
      r_cnt       <= {CNT_W{1'b0}};
      o_sel_iso   <= 1'b0;
      o_pd_rst    <= 1'b0;
      o_pd_pwr_en <= 1'b1;
      o_pd_ack    <= 1'b0;
      o_pd_err    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      o_sel_iso   <= w_sel_iso_nxt;
      o_pd_rst    <= w_pd_rst_nxt;
      o_pd_pwr_en <= w_pwr_en_nxt;
      o_pd_ack    <= w_ack_nxt;
      o_pd_err    <= w_err_nxt;
    end
  end

  // Next-state and counter reload; pwr_ok wins over a coincident timeout
  always_comb begin
    w_state_nxt = r_state;
    w_err_set   = 1'b0;
    w_err_clr   = 1'b0;
    case (r_state)
      S_ON: begin
        if (i_pd_off_req) begin
          w_state_nxt = S_ISO;
          w_err_clr   = 1'b1;
        end else begin
          w_state_nxt = S_ON;
        end
      end
      S_ISO:     w_state_nxt = w_cnt_done ? S_RST     : S_ISO;
      S_RST:     w_state_nxt = w_cnt_done ? S_PWR_DN  : S_RST;
      S_PWR_DN: begin
        if (!i_pd_pwr_ok) begin
          w_state_nxt = S_OFF;
        end else if (w_cnt_done) begin
          w_state_nxt = S_OFF;
          w_err_set   = 1'b1;
        end else begin
          w_state_nxt = S_PWR_DN;
        end
      end
      S_OFF: begin
        if (i_pd_on_req) begin
          w_state_nxt = S_PWR_UP;
          w_err_clr   = 1'b1;
        end else begin
          w_state_nxt = S_OFF;
        end
      end
      S_PWR_UP: begin
        if (i_pd_pwr_ok) begin
          w_state_nxt = S_RST_REL;
        end else if (w_cnt_done) begin
          w_state_nxt = S_OFF;
          w_err_set   = 1'b1;
        end else begin
          w_state_nxt = S_PWR_UP;
        end
      end
      S_RST_REL: w_state_nxt = w_cnt_done ? S_ISO_REL : S_RST_REL;
      S_ISO_REL: w_state_nxt = w_cnt_done ? S_ON      : S_ISO_REL;
      default:   w_state_nxt = S_ON;
    endcase

    if (w_state_nxt != r_state) begin
      case (w_state_nxt)
        S_ISO, S_ISO_REL:   w_cnt_nxt = ISO_LD;
        S_RST, S_RST_REL:   w_cnt_nxt = RST_LD;
        S_PWR_DN, S_PWR_UP: w_cnt_nxt = TMO_LD;
        default:            w_cnt_nxt = {CNT_W{1'b0}};
      endcase
    end else if (!w_cnt_done) begin
      w_cnt_nxt = r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      w_cnt_nxt = r_cnt;
    end
  end

  // Output decode from the next state
  always_comb begin
    w_sel_iso_nxt = (w_state_nxt != S_ON);
    case (w_state_nxt)
      S_RST, S_PWR_DN, S_OFF, S_PWR_UP, S_RST_REL: w_pd_rst_nxt = 1'b1;
      default:                                     w_pd_rst_nxt = 1'b0;
    endcase
    w_pwr_en_nxt = !((w_state_nxt == S_PWR_DN) || (w_state_nxt == S_OFF));
    w_ack_nxt    = (w_state_nxt != r_state) && ((w_state_nxt == S_OFF) || (w_state_nxt == S_ON));
    if (w_err_set) begin
      w_err_nxt = 1'b1;
    end else if (w_err_clr) begin
      w_err_nxt = 1'b0;
    end else begin
      w_err_nxt = o_pd_err;
    end
  end

  assign o_pd_state = r_state;

endmodule

// File: tb/tb_aopd_pd_seq.sv
// Directed bench for aopd_pd_seq with a 3-cycle pwr_ok model and a random invariant stress phase.
module tb_aopd_pd_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       off_req = 1'b0;
  logic       on_req = 1'b0;
  logic       pwr_ok;
  logic       o_pd_ack, o_pd_err, o_sel_iso, o_pd_rst, o_pd_pwr_en;
  logic [2:0] o_pd_state;
  logic [2:0] r_ok_sh;
  logic       stuck_hi = 1'b0;
  logic       stuck_lo = 1'b0;
  int         n_chk = 0;
  int         n_pass = 0;

  aopd_pd_seq #(.ISO_DLY(4), .RST_DLY(4), .PWR_TMO(16), .CNT_W(8)) dut (
    .i_aopd_clk  (clk),
    .i_aopd_rst  (rst),
    .i_pd_off_req(off_req),
    .i_pd_on_req (on_req),
    .i_pd_pwr_ok (pwr_ok),
    .o_pd_ack    (o_pd_ack),
    .o_pd_err    (o_pd_err),
    .o_sel_iso   (o_sel_iso),
    .o_pd_rst    (o_pd_rst),
    .o_pd_pwr_en (o_pd_pwr_en),
    .o_pd_state  (o_pd_state)
  );

  always #5 clk = ~clk;

  // Power switch model: pwr_ok follows pwr_en three cycles later unless forced
  always @(posedge clk) begin
    if (rst) r_ok_sh <= 3'b111;
    else     r_ok_sh <= {r_ok_sh[1:0], o_pd_pwr_en};
  end
  assign pwr_ok = stuck_hi ? 1'b1 : (stuck_lo ? 1'b0 : r_ok_sh[2]);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input string tag, input int max);
    bit got = 1'b0;
    for (int i = 0; i < max && !got; i++) begin
      step();
      got = o_pd_ack;
    end
    chk(tag, {31'd0, got}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset
    step(); step();
    chk("rst_state", 32'(o_pd_state), 32'd0);
    chk("rst_sel", 32'(o_sel_iso), 32'd0);
    chk("rst_prst", 32'(o_pd_rst), 32'd0);
    chk("rst_en", 32'(o_pd_pwr_en), 32'd1);
    chk("rst_ack", 32'(o_pd_ack), 32'd0);
    chk("rst_err", 32'(o_pd_err), 32'd0);
    rst = 1'b0;
    step();
    chk("idle_state", 32'(o_pd_state), 32'd0);

    // Power-down, request held through and beyond the ack
    off_req = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      step();
      chk($sformatf("dn_sel@%0d", c), 32'(o_sel_iso), 32'd1);
      chk($sformatf("dn_prst@%0d", c), 32'(o_pd_rst), 32'(c >= 5));
      chk($sformatf("dn_en@%0d", c), 32'(o_pd_pwr_en), 32'(c < 9));
      chk($sformatf("dn_ack@%0d", c), 32'(o_pd_ack), 32'(c == 13));
      if (c == 1)  chk("dn_st1", 32'(o_pd_state), 32'd1);
      if (c == 5)  chk("dn_st5", 32'(o_pd_state), 32'd2);
      if (c == 9)  chk("dn_st9", 32'(o_pd_state), 32'd3);
      if (c == 12) chk("dn_st12", 32'(o_pd_state), 32'd3);
      if (c == 13) chk("dn_st13", 32'(o_pd_state), 32'd4);
    end
    for (int c = 0; c < 3; c++) begin
      step();
      chk("off_hold_state", 32'(o_pd_state), 32'd4);
      chk("off_hold_ack", 32'(o_pd_ack), 32'd0);
    end
    off_req = 1'b0;

    // Power-up
    on_req = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      step();
      chk($sformatf("up_en@%0d", c), 32'(o_pd_pwr_en), 32'd1);
      chk($sformatf("up_prst@%0d", c), 32'(o_pd_rst), 32'(c < 9));
      chk($sformatf("up_sel@%0d", c), 32'(o_sel_iso), 32'(c < 13));
      chk($sformatf("up_ack@%0d", c), 32'(o_pd_ack), 32'(c == 13));
      if (c == 1)  chk("up_st1", 32'(o_pd_state), 32'd5);
      if (c == 5)  chk("up_st5", 32'(o_pd_state), 32'd6);
      if (c == 9)  chk("up_st9", 32'(o_pd_state), 32'd7);
      if (c == 13) chk("up_st13", 32'(o_pd_state), 32'd0);
    end
    step();
    chk("on_hold_state", 32'(o_pd_state), 32'd0);
    on_req = 1'b0;

    // on_req alone in ON is ignored
    on_req = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      chk("on_ign_state", 32'(o_pd_state), 32'd0);
    end
    on_req = 1'b0;

    // Both requests in ON take the down path
    off_req = 1'b1;
    on_req  = 1'b1;
    step();
    chk("both_st1", 32'(o_pd_state), 32'd1);
    wait_ack("both_dn_ack", 20);
    chk("both_dn_state", 32'(o_pd_state), 32'd4);
    off_req = 1'b0;
    on_req  = 1'b0;
    step();
    chk("both_off_stay", 32'(o_pd_state), 32'd4);
    on_req = 1'b1;
    step();
    on_req = 1'b0;
    wait_ack("both_up_ack", 20);
    chk("both_up_state", 32'(o_pd_state), 32'd0);

    // Power-down timeout with pwr_ok stuck high
    step(); step(); step();
    stuck_hi = 1'b1;
    off_req  = 1'b1;
    for (int c = 1; c <= 25; c++) begin
      step();
      off_req = 1'b0;
      chk($sformatf("tmo_st@%0d", c), 32'(o_pd_state),
          (c < 5) ? 32'd1 : (c < 9) ? 32'd2 : (c < 25) ? 32'd3 : 32'd4);
      chk($sformatf("tmo_err@%0d", c), 32'(o_pd_err), 32'(c == 25));
      chk($sformatf("tmo_ack@%0d", c), 32'(o_pd_ack), 32'(c == 25));
    end
    stuck_hi = 1'b0;
    step();
    chk("tmo_err_sticky", 32'(o_pd_err), 32'd1);
    on_req = 1'b1;
    step();
    on_req = 1'b0;
    chk("tmo_err_clr", 32'(o_pd_err), 32'd0);
    chk("tmo_up_st", 32'(o_pd_state), 32'd5);
    wait_ack("tmo_up_ack", 20);
    chk("tmo_up_state", 32'(o_pd_state), 32'd0);

    // Power-up timeout with pwr_ok stuck low
    off_req = 1'b1;
    step();
    off_req = 1'b0;
    wait_ack("put_dn_ack", 20);
    stuck_lo = 1'b1;
    on_req   = 1'b1;
    for (int c = 1; c <= 17; c++) begin
      step();
      on_req = 1'b0;
      chk($sformatf("put_st@%0d", c), 32'(o_pd_state), (c < 17) ? 32'd5 : 32'd4);
      chk($sformatf("put_en@%0d", c), 32'(o_pd_pwr_en), 32'(c < 17));
      chk($sformatf("put_ack@%0d", c), 32'(o_pd_ack), 32'(c == 17));
      chk($sformatf("put_err@%0d", c), 32'(o_pd_err), 32'(c == 17));
    end
    stuck_lo = 1'b0;
    step(); step(); step(); step();
    on_req = 1'b1;
    step();
    on_req = 1'b0;
    wait_ack("put_up_ack", 20);
    chk("put_up_state", 32'(o_pd_state), 32'd0);
    chk("put_up_err", 32'(o_pd_err), 32'd0);

    // Reset in the middle of a power-down
    step(); step(); step();
    off_req = 1'b1;
    for (int c = 1; c <= 6; c++) step();
    chk("mid_st6", 32'(o_pd_state), 32'd2);
    rst     = 1'b1;
    off_req = 1'b0;
    step();
    chk("mid_state", 32'(o_pd_state), 32'd0);
    chk("mid_sel", 32'(o_sel_iso), 32'd0);
    chk("mid_prst", 32'(o_pd_rst), 32'd0);
    chk("mid_en", 32'(o_pd_pwr_en), 32'd1);
    chk("mid_ack", 32'(o_pd_ack), 32'd0);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("mid_post_ack", 32'(o_pd_ack), 32'd0);
      chk("mid_post_state", 32'(o_pd_state), 32'd0);
    end

    // Random stress of the isolation invariant
    for (int c = 0; c < 10000; c++) begin
      logic inv;
      if ((c % 64) == 0) begin
        int mode;
        mode     = int'($urandom_range(0, 5));
        stuck_hi = (mode == 0);
        stuck_lo = (mode == 1);
      end
      off_req = ($urandom_range(0, 7) == 0);
      on_req  = ($urandom_range(0, 7) == 0);
      step();
      inv = o_sel_iso | ~(o_pd_rst | ~o_pd_pwr_en);
      chk("invariant", {31'd0, inv}, 32'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
